// File: rtl/spike_encoder_if.sv
// spike_encoder_if: pixel load, spike vector and neuron step handshake between encoder and input layer
interface spike_encoder_if #(parameter int N_PIX = 16);
  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_ready;
  logic [N_PIX-1:0] spike_vec;
  logic             step_start;
  logic             start_core_img;
  logic             neuron_done;
  logic [7:0]       step_idx;
  logic             busy;
  logic             img_done;
  modport master (
    input  pix_valid, pix_data, neuron_done,
    output pix_ready, spike_vec, step_start, start_core_img, step_idx, busy, img_done
  );
  modport slave (
    output pix_valid, pix_data, neuron_done,
    input  pix_ready, spike_vec, step_start, start_core_img, step_idx, busy, img_done
  );
endinterface

// File: rtl/spike_encoder.sv
// spike_encoder: buffers one image and emits T_STEPS LFSR rate-coded spike vectors per image
module spike_encoder #(
  parameter int          N_PIX   = 16,
  parameter int          T_STEPS = 20,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  spike_encoder_if.master bus
);
  localparam int PW = N_PIX > 1 ? $clog2(N_PIX) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_PIX - 1);
  localparam logic [7:0] T_LAST = 8'(T_STEPS - 1);
  typedef enum logic [2:0] {LOAD, ARM, GEN, FIRE, WAIT, FIN} state_t;
  state_t           state_q;
  logic [7:0]       mem_q [N_PIX];
  logic [PW-1:0]    wr_ptr_q, ev_ptr_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [N_PIX-1:0] shadow_q, shadow_d, spike_q;
  logic             pix_ready_q, step_start_q, sci_q, busy_q, img_done_q;
  logic [7:0]       step_idx_q;
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    shadow_d = shadow_q;
    shadow_d[ev_ptr_q] = mem_q[ev_ptr_q] > lfsr_q[7:0];
  end
  // pixel storage is deliberately left unreset
  always_ff @(posedge clk)
    if (!rst && state_q == LOAD && bus.pix_valid) mem_q[wr_ptr_q] <= bus.pix_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      pix_ready_q <= 1'b1;
      spike_q <= '0;
      step_start_q <= 1'b0;
      sci_q <= 1'b0;
      step_idx_q <= '0;
      busy_q <= 1'b0;
      img_done_q <= 1'b0;
      lfsr_q <= SEED;
      wr_ptr_q <= '0;
      ev_ptr_q <= '0;
      shadow_q <= '0;
    end else begin
      step_start_q <= 1'b0;
      sci_q <= 1'b0;
      img_done_q <= 1'b0;
      case (state_q)
        LOAD: if (bus.pix_valid) begin
          wr_ptr_q <= wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) begin
            state_q <= ARM;
            pix_ready_q <= 1'b0;
            busy_q <= 1'b1;
            sci_q <= 1'b1;
            step_idx_q <= '0;
            ev_ptr_q <= '0;
          end
        end
        ARM: state_q <= GEN;
        GEN: begin
          shadow_q <= shadow_d;
          lfsr_q <= lfsr_d;
          ev_ptr_q <= ev_ptr_q == LAST ? '0 : ev_ptr_q + 1'b1;
          if (ev_ptr_q == LAST) begin
            state_q <= FIRE;
            spike_q <= shadow_d;
            step_start_q <= 1'b1;
          end
        end
        FIRE: state_q <= WAIT;
        WAIT: if (bus.neuron_done) begin
          if (step_idx_q == T_LAST) begin
            state_q <= FIN;
            img_done_q <= 1'b1;
            spike_q <= '0;
            step_idx_q <= '0;
          end else begin
            state_q <= GEN;
            step_idx_q <= step_idx_q + 1'b1;
          end
        end
        FIN: begin
          state_q <= LOAD;
          pix_ready_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state_q <= LOAD;
      endcase
    end
  assign bus.pix_ready = pix_ready_q;
  assign bus.spike_vec = spike_q;
  assign bus.step_start = step_start_q;
  assign bus.start_core_img = sci_q;
  assign bus.step_idx = step_idx_q;
  assign bus.busy = busy_q;
  assign bus.img_done = img_done_q;
endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: directed image loads checked against an LFSR rate-coding reference model
module tb_spike_encoder;
  localparam int N = 16, T = 20;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0, rst = 1'b0;
  spike_encoder_if #(.N_PIX(N)) bus ();
  spike_encoder #(.N_PIX(N), .T_STEPS(T), .SEED(SEED)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  logic [15:0] mlfsr;
  logic [7:0] img [N];
  logic [N-1:0] first_vec, or_vec;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [N-1:0] model_step();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = img[i] > mlfsr[7:0];
      mlfsr = {1'b0, mlfsr[15:1]} ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
    end
    return v;
  endfunction
  task automatic check_reset(input string nm);
    chk({nm, "_pix_ready"}, bus.pix_ready, 1);
    chk({nm, "_spike_vec"}, bus.spike_vec, 0);
    chk({nm, "_step_start"}, bus.step_start, 0);
    chk({nm, "_start_core_img"}, bus.start_core_img, 0);
    chk({nm, "_step_idx"}, bus.step_idx, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_img_done"}, bus.img_done, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    mlfsr = SEED;
  endtask
  task automatic load_image();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) chk("load_pix_ready", bus.pix_ready, 1);
      bus.pix_valid = 1'b1;
      bus.pix_data = img[i];
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    chk("arm_start_core_img", bus.start_core_img, 1);
    chk("arm_pix_ready", bus.pix_ready, 0);
    chk("arm_busy", bus.busy, 1);
    chk("arm_step_start", bus.step_start, 0);
  endtask
  task automatic run_image(input string nm, input int hold_step, input int abort_step);
    int steps = 0, last_c = 0, cyc = 0, done_at = -1, gen_c = 0, scs = 0;
    logic [N-1:0] exp_v, held;
    bit fin = 0, aborted = 0, pv_chk = 0;
    or_vec = '0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (bus.start_core_img) scs++;
      if (bus.step_start) begin
        exp_v = model_step();
        if (steps == 0) first_vec = bus.spike_vec;
        or_vec = or_vec | bus.spike_vec;
        chk({nm, "_spike_vec"}, bus.spike_vec, exp_v);
        chk({nm, "_step_idx"}, bus.step_idx, steps);
        chk({nm, "_no_overlap"}, bus.start_core_img, 0);
        if (steps > 0) chk({nm, "_period"}, cyc - last_c, N + 2 + ((steps - 1 == hold_step) ? 10 : 0));
        last_c = cyc;
        held = bus.spike_vec;
        done_at = cyc + 1 + ((steps == hold_step) ? 10 : 0);
        steps++;
      end
      if (hold_step >= 0 && steps - 1 == hold_step && cyc == done_at - 1) begin
        chk({nm, "_hold_spike_vec"}, bus.spike_vec, held);
        chk({nm, "_hold_step_idx"}, bus.step_idx, hold_step);
        chk({nm, "_hold_no_step_start"}, bus.step_start, 0);
      end
      if (steps == 2 && !pv_chk && !bus.step_start) begin
        chk({nm, "_run_pix_ready"}, bus.pix_ready, 0);
        pv_chk = 1;
      end
      if (bus.img_done) begin
        chk({nm, "_fin_spike_vec"}, bus.spike_vec, 0);
        chk({nm, "_fin_step_idx"}, bus.step_idx, 0);
        chk({nm, "_step_count"}, steps, T);
        chk({nm, "_extra_start_core_img"}, scs, 0);
        fin = 1;
      end
      if (abort_step >= 0 && steps == abort_step && bus.step_idx == abort_step && !bus.step_start) gen_c++;
      if (gen_c == 3) begin
        fin = 1;
        aborted = 1;
      end
      bus.neuron_done = (cyc == done_at);
      bus.pix_valid = (steps == 2);
      bus.pix_data = 8'hAA;
    end
    bus.pix_valid = 1'b0;
    bus.neuron_done = 1'b0;
    chk({nm, "_completed"}, fin, 1);
    if (aborted) begin
      rst = 1'b1;
      #1;
      check_reset({nm, "_abort"});
      @(negedge clk);
      rst = 1'b0;
      mlfsr = SEED;
      @(negedge clk);
      chk({nm, "_abort_no_img_done"}, bus.img_done, 0);
    end else begin
      @(negedge clk);
      chk({nm, "_post_pix_ready"}, bus.pix_ready, 1);
      chk({nm, "_post_busy"}, bus.busy, 0);
      chk({nm, "_post_img_done"}, bus.img_done, 0);
    end
  endtask
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'h00;
    bus.neuron_done = 1'b0;
    do_reset();
    foreach (img[i]) img[i] = 8'hFF;
    load_image();
    run_image("all255", -1, -1);
    chk("all255_first_bit0", first_vec[0], 1);
    foreach (img[i]) img[i] = 8'h00;
    load_image();
    run_image("zero", 3, -1);
    chk("zero_never_spikes", or_vec, 0);
    foreach (img[i]) img[i] = (i == 0) ? 8'hFF : 8'h00;
    load_image();
    run_image("p0only", -1, -1);
    chk("p0only_upper_zero", or_vec[N-1:1], 0);
    chk("p0only_bit0_seen", or_vec[0], 1);
    foreach (img[i]) img[i] = 8'(i * 16 + 8);
    load_image();
    run_image("abort", -1, 5);
    load_image();
    run_image("reload", -1, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
